// File: rtl/rr_arbiter8_if.sv
// rtl/rr_arbiter8_if.sv - requester/downstream handshake bundle for rr_arbiter8
interface rr_arbiter8_if;
  logic [7:0] req;
  logic [7:0] req_last;
  logic       out_ready;
  logic       out_valid;
  logic       out_last;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout_err;

  modport master (
    output req, req_last, out_ready,
    input  out_valid, out_last, sel, gnt, busy, timeout_err
  );

  modport slave (
    input  req, req_last, out_ready,
    output out_valid, out_last, sel, gnt, busy, timeout_err
  );
endinterface

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin burst arbiter driving a mux8 select
// Optional forced release of stalled bursts when ARB_TIMEOUT_EN is defined.
module rr_arbiter8 #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_arbiter8_if.slave    bus
);

  if (WIDTH < 1 || TIMEOUT < 1) begin : g_param_check
    $error("rr_arbiter8: WIDTH and TIMEOUT must be positive");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic       accept;
  logic       any_req;
  logic       timeout_hit;
  logic [2:0] pick_base;
  logic [2:0] pick_idx;

  // First set bit searching base+1, base+2, ... wrapping; base itself is checked last.
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] base);
    logic [2:0] idx;
    pick = base;
    for (int k = 8; k >= 1; k--) begin
      idx = base + 3'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign bus.busy      = (state_q == GRANT);
  assign bus.out_valid = (state_q == GRANT) && bus.req[sel_q];
  assign bus.out_last  = (state_q == GRANT) && bus.req_last[sel_q];
  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;

  assign accept    = bus.out_valid && bus.out_ready;
  assign any_req   = |bus.req;
  // At a burst end the pointer becomes the current grant, so search from it directly.
  assign pick_base = (state_q == GRANT) ? sel_q : ptr_q;
  assign pick_idx  = pick(bus.req, pick_base);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic             timeout_err_q;

  assign timeout_hit = (state_q == GRANT) && !accept && (stall_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    stall_d = '0;
    if (state_q == GRANT && !accept && !timeout_hit) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      stall_q       <= stall_d;
      timeout_err_q <= timeout_hit;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d   = pick_idx;
          gnt_d   = 8'b1 << pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (accept && bus.out_last) begin
          ptr_d = sel_q;
          if (any_req) begin
            sel_d = pick_idx;
            gnt_d = 8'b1 << pick_idx;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if (timeout_hit) begin
          ptr_d   = sel_q;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd7;
      gnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

endmodule
